// File: rtl/id_ctrl_stage_pkg.sv
// Shared ISA constants, control-bundle layout and buffer state type for the
// decode/control stage.
package id_ctrl_stage_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct3 values (instr[14:12])
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_JALR    = 3'b000;

  // funct7 values (instr[31:25])
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU operation encoding: {alt, funct3} for the shift/arith group
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_SRA    = 4'b1101,
    ALU_PASS_A = 4'b1111
  } alu_op_e;

  // Control bundle layout, MSB first:
  // {branch,MemRead,MemToReg,ALU_op[3:0],MemWrite,ALUSrc,RegWrite,
  //  is_branch,is_jump,is_jal,is_jalr,is_load,is_store}
  localparam int unsigned CTRL_W         = 16;
  localparam int unsigned CTRL_BRANCH    = 15;
  localparam int unsigned CTRL_MEMREAD   = 14;
  localparam int unsigned CTRL_MEMTOREG  = 13;
  localparam int unsigned CTRL_ALU_HI    = 12;
  localparam int unsigned CTRL_ALU_LO    = 9;
  localparam int unsigned CTRL_MEMWRITE  = 8;
  localparam int unsigned CTRL_ALUSRC    = 7;
  localparam int unsigned CTRL_REGWRITE  = 6;
  localparam int unsigned CTRL_IS_BRANCH = 5;
  localparam int unsigned CTRL_IS_JUMP   = 4;
  localparam int unsigned CTRL_IS_JAL    = 3;
  localparam int unsigned CTRL_IS_JALR   = 2;
  localparam int unsigned CTRL_IS_LOAD   = 1;
  localparam int unsigned CTRL_IS_STORE  = 0;

  // Decoder result carried through the buffer alongside pc/instr
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              md_en;
    logic [2:0]        md_op;
    logic              illegal;
  } dec_t;

  // Occupancy of the main+skid output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // ALU op for the register/immediate arithmetic group; alt selects SUB/SRA
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      FUNCT3_ADD_SUB: if (alt) op = ALU_SUB; else op = ALU_ADD;
      FUNCT3_SLL:     op = ALU_SLL;
      FUNCT3_SLT:     op = ALU_SLT;
      FUNCT3_SLTU:    op = ALU_SLTU;
      FUNCT3_XOR:     op = ALU_XOR;
      FUNCT3_SRL_SRA: if (alt) op = ALU_SRA; else op = ALU_SRL;
      FUNCT3_OR:      op = ALU_OR;
      default:        op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ctrl_stage_if.sv
// IF->ID->EX handshake bundle for the decode/control stage. The master side
// is the surrounding pipeline (IF producer, EX consumer, redirect source);
// the slave side is the stage itself.
interface id_ctrl_stage_if #(
  parameter int unsigned XLEN = 32
);
  import id_ctrl_stage_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_md_en;
  logic [2:0]        out_md_op;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_ctrl,
           out_md_en, out_md_op, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_ctrl,
           out_md_en, out_md_op, out_illegal
  );

endinterface

// File: rtl/id_ctrl_stage_ctrl_decode.sv
// Pure combinational RV32I(+M) decoder: opcode/funct fields -> control
// bundle, M-ext op and illegal flag. Illegal encodings decode as a NOP.
module ctrl_decode
  import id_ctrl_stage_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_o
);

  logic    branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic    is_branch, is_jump, is_jal, is_jalr, is_load, is_store;
  logic    md_en, illegal;
  logic [2:0] md_op;
  alu_op_e alu_op;

  // Per-opcode flag decode; illegal paths leave every flag at its NOP default
  always_comb begin
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    md_en      = 1'b0;
    md_op      = 3'b000;
    illegal    = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode_i)
      OP_R_TYPE: begin
        if ((funct7_i == FUNCT7_BASE) || (funct7_i == FUNCT7_ALT)) begin
          reg_write = 1'b1;
          alu_op    = alu_from_funct(funct3_i, funct7_i[5]);
        end else if (ENABLE_M && (funct7_i == FUNCT7_MULDIV)) begin
          reg_write = 1'b1;
          md_en     = 1'b1;
          md_op     = funct3_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I_TYPE: begin
        if ((funct3_i == FUNCT3_SLL) && (funct7_i != FUNCT7_BASE)) begin
          illegal = 1'b1;
        end else if ((funct3_i == FUNCT3_SRL_SRA) &&
                     (funct7_i != FUNCT7_BASE) && (funct7_i != FUNCT7_ALT)) begin
          illegal = 1'b1;
        end else begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          // Only the shift-right form uses funct7 to pick the variant
          alu_op    = alu_from_funct(funct3_i,
                                     (funct3_i == FUNCT3_SRL_SRA) && funct7_i[5]);
        end
      end
      OP_LOAD: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        is_load    = 1'b1;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        is_store  = 1'b1;
      end
      OP_BRANCH: begin
        branch    = 1'b1;
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        is_jump   = 1'b1;
        is_jal    = 1'b1;
      end
      OP_JALR: begin
        if (funct3_i != FUNCT3_JALR) begin
          illegal = 1'b1;
        end else begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          is_jump   = 1'b1;
          is_jalr   = 1'b1;
        end
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_PASS_A;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Pack the bundle; an illegal entry carries an all-zero control word
  always_comb begin
    dec_o         = '0;
    dec_o.illegal = illegal;
    if (!illegal) begin
      dec_o.ctrl[CTRL_BRANCH]               = branch;
      dec_o.ctrl[CTRL_MEMREAD]              = mem_read;
      dec_o.ctrl[CTRL_MEMTOREG]             = mem_to_reg;
      dec_o.ctrl[CTRL_ALU_HI:CTRL_ALU_LO]   = alu_op;
      dec_o.ctrl[CTRL_MEMWRITE]             = mem_write;
      dec_o.ctrl[CTRL_ALUSRC]               = alu_src;
      dec_o.ctrl[CTRL_REGWRITE]             = reg_write;
      dec_o.ctrl[CTRL_IS_BRANCH]            = is_branch;
      dec_o.ctrl[CTRL_IS_JUMP]              = is_jump;
      dec_o.ctrl[CTRL_IS_JAL]               = is_jal;
      dec_o.ctrl[CTRL_IS_JALR]              = is_jalr;
      dec_o.ctrl[CTRL_IS_LOAD]              = is_load;
      dec_o.ctrl[CTRL_IS_STORE]             = is_store;
      dec_o.md_en                           = md_en;
      dec_o.md_op                           = md_op;
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode/control stage between IF and EX. Decodes on capture and
// holds results in a main register backed by an optional skid entry so EX
// back-pressure never drops an instruction; flush empties the buffer.
module id_ctrl_stage
  import id_ctrl_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0,
  parameter bit          SKID     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ctrl_stage_if.slave bus
);

  buf_state_e      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, main_instr_q, main_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
  dec_t            main_dec_q, main_dec_d, skid_dec_q, skid_dec_d;
  dec_t            in_dec;
  logic            in_ready, out_valid, in_xfer, out_xfer;

  ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_ctrl_decode (
    .opcode_i (bus.in_instr[6:0]),
    .funct3_i (bus.in_instr[14:12]),
    .funct7_i (bus.in_instr[31:25]),
    .dec_o    (in_dec)
  );

  assign out_valid = (state_q != BUF_EMPTY);
  // Without the skid entry the single register may refill on the edge it drains
  assign in_ready  = SKID ? in_ready_q : ((state_q == BUF_EMPTY) || bus.out_ready);
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;

  // Buffer occupancy FSM plus data steering between main and skid entries
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_dec_d   = main_dec_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_dec_d   = skid_dec_q;
    if (bus.flush) begin
      // Data registers are left untouched so a dropped instruction never lands
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_xfer) begin
            main_pc_d    = bus.in_pc;
            main_instr_d = bus.in_instr;
            main_dec_d   = in_dec;
            state_d      = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_xfer && out_xfer) begin
            main_pc_d    = bus.in_pc;
            main_instr_d = bus.in_instr;
            main_dec_d   = in_dec;
          end else if (in_xfer && SKID) begin
            skid_pc_d    = bus.in_pc;
            skid_instr_d = bus.in_instr;
            skid_dec_d   = in_dec;
            state_d      = BUF_TWO;
          end else if (out_xfer) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (out_xfer) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            main_dec_d   = skid_dec_q;
            state_d      = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    in_ready_d = (state_d != BUF_TWO);
  end

  // State and registered ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Main and skid entry payload registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_pc_q    <= '0;
      main_instr_q <= '0;
      main_dec_q   <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_dec_q   <= '0;
    end else begin
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      main_dec_q   <= main_dec_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_dec_q   <= skid_dec_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = main_pc_q;
  assign bus.out_instr   = main_instr_q;
  assign bus.out_ctrl    = main_dec_q.ctrl;
  assign bus.out_md_en   = main_dec_q.md_en;
  assign bus.out_md_op   = main_dec_q.md_op;
  assign bus.out_illegal = main_dec_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: table of hand-decoded instructions streamed through
// two instances (ENABLE_M=0 and 1), directed back-pressure/flush sequences and
// a random handshake run checked against a queue of the table's expectations.
module tb_id_ctrl_stage;
  import id_ctrl_stage_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] ctrl0;
    logic        ill0;
    logic [15:0] ctrl1;
    logic        ill1;
    logic        md1;
    logic [2:0]  mdop1;
  } vec_t;

  typedef struct {
    int unsigned idx;
    logic [31:0] pc;
  } sb_t;

  localparam int unsigned NV = 18;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   delivered;
  int   d0;
  int unsigned cur_idx;
  int unsigned maxd;
  logic [31:0] last_pc;
  logic [31:0] rnd_pc;
  logic hold;
  bit   sb_on;
  vec_t vecs [NV];
  sb_t  sbq [$];

  id_ctrl_stage_if #(.XLEN(32)) bus0 ();
  id_ctrl_stage_if #(.XLEN(32)) bus1 ();

  assign bus1.flush     = bus0.flush;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_pc     = bus0.in_pc;
  assign bus1.in_instr  = bus0.in_instr;
  assign bus1.out_ready = bus0.out_ready;

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b0), .SKID(1'b1)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
  );

  id_ctrl_stage #(.XLEN(32), .ENABLE_M(1'b1), .SKID(1'b1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample handshakes at the falling edge, then advance to just after the rising edge
  task automatic cycle();
    logic in_x, out_x;
    sb_t  e;
    @(negedge clk);
    in_x  = bus0.in_valid && bus0.in_ready && !bus0.flush;
    out_x = bus0.out_valid && bus0.out_ready;
    hold  = bus0.in_valid && !bus0.in_ready && !bus0.flush;
    if (out_x === 1'b1) begin
      delivered++;
      last_pc = bus0.out_pc;
    end
    if (sb_on) begin
      if (out_x === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc",     bus0.out_pc,              e.pc);
          chk("sb_instr",  bus0.out_instr,           vecs[e.idx].instr);
          chk("sb_ctrl0",  {16'd0, bus0.out_ctrl},   {16'd0, vecs[e.idx].ctrl0});
          chk("sb_ill0",   {31'd0, bus0.out_illegal}, {31'd0, vecs[e.idx].ill0});
          chk("sb_ctrl1",  {16'd0, bus1.out_ctrl},   {16'd0, vecs[e.idx].ctrl1});
          chk("sb_ill1",   {31'd0, bus1.out_illegal}, {31'd0, vecs[e.idx].ill1});
          chk("sb_md1",    {28'd0, bus1.out_md_op, bus1.out_md_en},
                           {28'd0, vecs[e.idx].mdop1, vecs[e.idx].md1});
        end
      end
      if (bus0.flush) sbq.delete();
      else if (in_x === 1'b1) sbq.push_back('{cur_idx, bus0.in_pc});
      if (sbq.size() > maxd) maxd = sbq.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl);
    bus0.in_valid  = v;
    bus0.in_pc     = pc;
    bus0.in_instr  = instr;
    bus0.out_ready = ordy;
    bus0.flush     = fl;
  endtask

  initial begin
    checks = 0; errors = 0; delivered = 0; hold = 1'b0; sb_on = 1'b0;
    maxd = 0; cur_idx = 0; last_pc = '0;
    //             instr         ctrl0    ill0  ctrl1    ill1  md1   mdop1
    vecs[0]  = '{32'h003100B3, 16'h0040, 1'b0, 16'h0040, 1'b0, 1'b0, 3'd0}; // ADD
    vecs[1]  = '{32'h403100B3, 16'h1040, 1'b0, 16'h1040, 1'b0, 1'b0, 3'd0}; // SUB
    vecs[2]  = '{32'h0000A083, 16'h60C2, 1'b0, 16'h60C2, 1'b0, 1'b0, 3'd0}; // LW
    vecs[3]  = '{32'h0020A023, 16'h0181, 1'b0, 16'h0181, 1'b0, 1'b0, 3'd0}; // SW
    vecs[4]  = '{32'h00208063, 16'h9020, 1'b0, 16'h9020, 1'b0, 1'b0, 3'd0}; // BEQ
    vecs[5]  = '{32'h00500093, 16'h00C0, 1'b0, 16'h00C0, 1'b0, 1'b0, 3'd0}; // ADDI
    vecs[6]  = '{32'h40315093, 16'h1AC0, 1'b0, 16'h1AC0, 1'b0, 1'b0, 3'd0}; // SRAI
    vecs[7]  = '{32'h40311093, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd0}; // SLLI f7!=0
    vecs[8]  = '{32'h000100E7, 16'h00D4, 1'b0, 16'h00D4, 1'b0, 1'b0, 3'd0}; // JALR
    vecs[9]  = '{32'h000010E7, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd0}; // JALR f3!=0
    vecs[10] = '{32'h000000EF, 16'h00D8, 1'b0, 16'h00D8, 1'b0, 1'b0, 3'd0}; // JAL
    vecs[11] = '{32'h123450B7, 16'h1EC0, 1'b0, 16'h1EC0, 1'b0, 1'b0, 3'd0}; // LUI
    vecs[12] = '{32'h00001097, 16'h00C0, 1'b0, 16'h00C0, 1'b0, 1'b0, 3'd0}; // AUIPC
    vecs[13] = '{32'h003150B3, 16'h0A40, 1'b0, 16'h0A40, 1'b0, 1'b0, 3'd0}; // SRL
    vecs[14] = '{32'h0000007F, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd0}; // opcode 7F
    vecs[15] = '{32'h023100B3, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 3'd0}; // MUL
    vecs[16] = '{32'h023150B3, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 3'd5}; // DIVU
    vecs[17] = '{32'hFE3100B3, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd0}; // R f7=7F

    // Reset with traffic offered
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0040, 32'h003100B3, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("rst_out_valid", {31'd0, bus0.out_valid},   32'd0);
    chk("rst_in_ready",  {31'd0, bus0.in_ready},    32'd1);
    chk("rst_ctrl",      {16'd0, bus0.out_ctrl},    32'd0);
    chk("rst_pc",        bus0.out_pc,               32'd0);
    chk("rst_instr",     bus0.out_instr,            32'd0);
    chk("rst_md",        {28'd0, bus0.out_md_op, bus0.out_md_en}, 32'd0);
    chk("rst_illegal",   {31'd0, bus0.out_illegal}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();

    // Table stream, one per cycle, visible right after the capturing edge
    d0 = delivered;
    for (int unsigned i = 0; i < NV; i++) begin
      drive(1'b1, 32'h1000 + 4 * i, vecs[i].instr, 1'b1, 1'b0);
      chk("tab_in_ready", {31'd0, bus0.in_ready}, 32'd1);
      cycle();
      chk("tab_valid", {31'd0, bus0.out_valid},   32'd1);
      chk("tab_pc",    bus0.out_pc,               32'h1000 + 4 * i);
      chk("tab_instr", bus0.out_instr,            vecs[i].instr);
      chk("tab_ctrl0", {16'd0, bus0.out_ctrl},    {16'd0, vecs[i].ctrl0});
      chk("tab_ill0",  {31'd0, bus0.out_illegal}, {31'd0, vecs[i].ill0});
      chk("tab_md0",   {28'd0, bus0.out_md_op, bus0.out_md_en}, 32'd0);
      chk("tab_ctrl1", {16'd0, bus1.out_ctrl},    {16'd0, vecs[i].ctrl1});
      chk("tab_ill1",  {31'd0, bus1.out_illegal}, {31'd0, vecs[i].ill1});
      chk("tab_md1",   {28'd0, bus1.out_md_op, bus1.out_md_en},
                       {28'd0, vecs[i].mdop1, vecs[i].md1});
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    chk("tab_drained",   {31'd0, bus0.out_valid}, 32'd0);
    chk("tab_delivered", delivered - d0,          NV);

    // Back-pressure: three offered, two held, order kept on drain
    d0 = delivered;
    drive(1'b1, 32'h100, vecs[0].instr, 1'b0, 1'b0);
    cycle();
    chk("bp_a_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("bp_a_pc",    bus0.out_pc,             32'h100);
    chk("bp_rdy_one", {31'd0, bus0.in_ready},  32'd1);
    drive(1'b1, 32'h104, vecs[1].instr, 1'b0, 1'b0);
    cycle();
    chk("bp_rdy_two", {31'd0, bus0.in_ready},  32'd0);
    chk("bp_hold_pc", bus0.out_pc,             32'h100);
    drive(1'b1, 32'h108, vecs[2].instr, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 2; k++) begin
      cycle();
      chk("bp_stall_rdy",   {31'd0, bus0.in_ready}, 32'd0);
      chk("bp_stall_pc",    bus0.out_pc,            32'h100);
      chk("bp_stall_instr", bus0.out_instr,         vecs[0].instr);
      chk("bp_stall_ctrl",  {16'd0, bus0.out_ctrl}, {16'd0, vecs[0].ctrl0});
    end
    bus0.out_ready = 1'b1;
    cycle();
    chk("bp_b_pc",   bus0.out_pc,             32'h104);
    chk("bp_b_ctrl", {16'd0, bus0.out_ctrl},  {16'd0, vecs[1].ctrl0});
    chk("bp_b_rdy",  {31'd0, bus0.in_ready},  32'd1);
    cycle();
    chk("bp_c_pc",   bus0.out_pc,             32'h108);
    chk("bp_c_ctrl", {16'd0, bus0.out_ctrl},  {16'd0, vecs[2].ctrl0});
    bus0.in_valid = 1'b0;
    cycle();
    chk("bp_empty", {31'd0, bus0.out_valid}, 32'd0);
    chk("bp_count", delivered - d0,          32'd3);

    // Flush while full, offered instruction must vanish
    drive(1'b1, 32'h200, vecs[3].instr, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h204, vecs[4].instr, 1'b0, 1'b0);
    cycle();
    chk("fl_full", {31'd0, bus0.in_ready}, 32'd0);
    drive(1'b1, 32'h208, vecs[5].instr, 1'b0, 1'b1);
    cycle();
    chk("fl_two_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("fl_two_rdy",   {31'd0, bus0.in_ready},  32'd1);
    // Flush in ONE with an accepted-looking input: it is dropped too
    drive(1'b1, 32'h210, vecs[6].instr, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h214, vecs[8].instr, 1'b0, 1'b1);
    cycle();
    chk("fl_one_valid", {31'd0, bus0.out_valid}, 32'd0);
    d0 = delivered;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("fl_no_ghost", {31'd0, bus0.out_valid}, 32'd0);
    chk("fl_no_deliv", delivered - d0,          32'd0);
    // Flush coinciding with an out transfer: that entry is delivered
    drive(1'b1, 32'h300, vecs[3].instr, 1'b0, 1'b0);
    cycle();
    d0 = delivered;
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    chk("fl_x_count", delivered - d0,          32'd1);
    chk("fl_x_pc",    last_pc,                 32'h300);
    chk("fl_x_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("fl_x_rdy",   {31'd0, bus0.in_ready},  32'd1);
    bus0.flush = 1'b0;
    cycle();

    // Random handshake/flush stream against the table-backed scoreboard
    sb_on  = 1'b1;
    rnd_pc = 32'h4000;
    hold   = 1'b0;
    for (int unsigned n = 0; n < 3000; n++) begin
      if (!hold) begin
        bus0.in_valid = ($urandom_range(0, 3) != 0);
        cur_idx       = $urandom_range(0, NV - 1);
        bus0.in_instr = vecs[cur_idx].instr;
        rnd_pc        = rnd_pc + 32'd4;
        bus0.in_pc    = rnd_pc;
      end
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      bus0.flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) cycle();
    sb_on = 1'b0;
    chk("sb_drained",   sbq.size(),              32'd0);
    chk("sb_max_depth", maxd,                    32'd2);
    chk("sb_idle",      {31'd0, bus0.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
